snoop_bus_arbiter: RTL and testbench
====================================

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

Interface
REQ-001 Parameter FLUSH_TIMEOUT, default 8: maximum cycles spent in FLUSH before forced completion.
REQ-002 Clock  input  1  single clock; all state updates on posedge Clock.
REQ-003 Resetn  input  1  reset, asynchronous, active-low.
REQ-004 req  input  2  per-cache bus request (bit0 = cache 0, bit1 = cache 1); held high until done.
REQ-005 reqCmd0 / reqCmd1  input  3 each  requested bus command: 001 BusRd, 010 BusRdX, 011 BusUpgr.
REQ-006 snoopState  input  3  MESI state of the line in the non-owning cache: I=001, S=010, M=011, E=100.
REQ-007 flushDone  input  1  non-owning cache has written back its modified line.
REQ-008 grant  output  2  one-hot bus grant.
REQ-009 busCmd  output  3  broadcast command: 000 empty, 001 BusRd, 010 BusRdX, 011 BusUpgr.
REQ-010 shared  output  1  registered; another cache held the line (S/E/M) on a BusRd.
REQ-011 done  output  2  one-cycle completion pulse to the owner.
REQ-012 err  output  1  one-cycle pulse with done on flush timeout or illegal command.

Function
REQ-013 FSM states: IDLE, GRANT, SNOOP, FLUSH, DONE; one state per cycle except FLUSH.
REQ-014 IDLE: with req != 00, select the winner, latch its reqCmd, and go to GRANT; otherwise stay in IDLE.
REQ-015 Arbitration is round-robin: on simultaneous requests, grant the cache not granted last; after reset, cache 0 wins.
REQ-016 grant is one-hot to the owner in GRANT, SNOOP, FLUSH and DONE; it is 00 in IDLE.
REQ-017 busCmd drives the latched command in GRANT, SNOOP and FLUSH; it is 000 in IDLE and DONE.
REQ-018 GRANT always advances to SNOOP.
REQ-019 SNOOP samples snoopState:
- if it is M and the command is BusRd or BusRdX, go to FLUSH;
- otherwise go to DONE.
REQ-020 shared is loaded in SNOOP: 1 if the command is BusRd and snoopState is S, E or M; otherwise 0. It holds until the next SNOOP.
REQ-021 FLUSH: on flushDone go to DONE; on the FLUSH_TIMEOUT-th FLUSH cycle without flushDone, go to DONE with err.
REQ-022 The FLUSH counter clears on entry to FLUSH and saturates; it never wraps.
REQ-023 DONE asserts done[owner] for one cycle, updates the round-robin pointer, and returns to IDLE.
REQ-024 A latched command of 000 or 1xx takes the path GRANT, then SNOOP, then DONE with err=1 and busCmd held at 000 throughout.
REQ-025 Latency with no flush: req sampled in IDLE at cycle N; GRANT at N+1; SNOOP at N+2; done at N+3; next grant no earlier than N+5.
REQ-026 Deassertion of req, or a change of reqCmd, during a transaction is ignored; the transaction completes.
REQ-027 flushDone outside FLUSH is ignored.
REQ-028 snoopState outside SNOOP is ignored.

Reset
REQ-029 Resetn low forces, asynchronously:
- state IDLE;
- grant 00, busCmd 000, shared 0, done 00, err 0;
- round-robin pointer favours cache 0;
- FLUSH counter 0.
REQ-030 Reset mid-transaction aborts it with no done pulse.
REQ-031 After Resetn rises, the first arbitration occurs on the first posedge.

Structure
REQ-032 MESI encodings, bus-command encodings and the FSM state enum belong in shared package snoop_pkg.
REQ-033 Round-robin selection is a separate sub-module rr_arb2 (inputs req and last-owner; output one-hot winner).

Verification
REQ-034 req=01, reqCmd0=001, snoopState=001:
- grant=01 at N+1;
- busCmd=001 at N+1 and N+2;
- shared=0;
- done=01 at N+3.
REQ-035 req=11 held, both caches issuing BusRd: grants alternate 01, 10, 01; the first grant goes to cache 0 after reset.
REQ-036 req=10, reqCmd1=010, snoopState=011, flushDone pulsed 3 cycles after FLUSH entry:
- FLUSH lasts 3 cycles;
- done=10;
- err=0.
REQ-037 Same as REQ-036 with flushDone never asserted: done=10 and err=1 after exactly FLUSH_TIMEOUT FLUSH cycles.
REQ-038 reqCmd0=001, snoopState=100: shared=1 from N+3; the BusUpgr request that follows leaves shared at 0.
REQ-039 Resetn low during SNOOP:
- grant and busCmd zero immediately;
- no done pulse;
- a pending req is regranted on the first posedge after release.

Source files
------------

// File: rtl/snoop_bus_arbiter_pkg.sv
`default_nettype none
//============================================================================
// Package : snoop_pkg
// MESI and bus-command encodings plus arbiter FSM state type.
// Rev     : 1.0
//============================================================================
package snoop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_SNOOP = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        MESI_I = 3'b001,
        MESI_S = 3'b010,
        MESI_M = 3'b011,
        MESI_E = 3'b100
    } mesi_t;

    typedef enum logic [2:0] {
        CMD_EMPTY   = 3'b000,
        CMD_BUSRD   = 3'b001,
        CMD_BUSRDX  = 3'b010,
        CMD_BUSUPGR = 3'b011
    } bus_cmd_t;

    function automatic logic is_legal_cmd(input logic [2:0] cmd);
        return (cmd == CMD_BUSRD) || (cmd == CMD_BUSRDX) || (cmd == CMD_BUSUPGR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_bus_arbiter_if.sv
`default_nettype none
//============================================================================
// Interface : snoop_bus_arbiter_if
// Request/snoop inputs and grant/command/completion outputs of the arbiter.
// Rev       : 1.0
//============================================================================
interface snoop_bus_arbiter_if;
    logic [1:0] req;
    logic [2:0] reqCmd0;
    logic [2:0] reqCmd1;
    logic [2:0] snoopState;
    logic       flushDone;
    logic [1:0] grant;
    logic [2:0] busCmd;
    logic       shared;
    logic [1:0] done;
    logic       err;

    modport slave (
        input  req, reqCmd0, reqCmd1, snoopState, flushDone,
        output grant, busCmd, shared, done, err
    );

    modport master (
        output req, reqCmd0, reqCmd1, snoopState, flushDone,
        input  grant, busCmd, shared, done, err
    );
endinterface
`default_nettype wire

// File: rtl/snoop_bus_arbiter_rr_arb2.sv
`default_nettype none
//============================================================================
// Module : rr_arb2
// Two-way round-robin selector; on a tie the cache not served last wins.
// Rev    : 1.0
//============================================================================
module rr_arb2 (
    input  wire logic [1:0] i_req,
    input  wire logic       i_last_owner,
    output logic [1:0]      o_winner
);
    always_comb begin
        o_winner = 2'b00;
        case (i_req)
            2'b01:   o_winner = 2'b01;
            2'b10:   o_winner = 2'b10;
            2'b11:   o_winner = i_last_owner ? 2'b01 : 2'b10;
            default: o_winner = 2'b00;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
//============================================================================
// Module : snoop_bus_arbiter
// Two-cache MESI snoop bus arbiter with bounded write-back flush.
// Rev    : 1.0
//============================================================================
module snoop_bus_arbiter
    import snoop_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 8
) (
    input  wire logic          Clock,
    input  wire logic          Resetn,
    snoop_bus_arbiter_if.slave bus
);
    localparam int                 c_cnt_w    = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FLUSH_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_owner;
    logic               r_last;
    logic [2:0]         r_cmd;
    logic               r_illegal;
    logic               r_timeout;
    logic               r_shared;
    logic [c_cnt_w-1:0] r_flush_cnt;
    logic [1:0]         w_win;
    logic               w_win1;
    logic [1:0]         w_grant_vec;
    logic [2:0]         w_cmd_out;
    logic               w_timeout_hit;
    logic               w_flush_req;

    rr_arb2 u_rr_arb2 (
        .i_req        (bus.req),
        .i_last_owner (r_last),
        .o_winner     (w_win)
    );

    assign w_win1        = (w_win == 2'b10);
    assign w_grant_vec   = r_owner ? 2'b10 : 2'b01;
    assign w_cmd_out     = r_illegal ? CMD_EMPTY : r_cmd;
    // Fires on the FLUSH_TIMEOUT-th FLUSH cycle; flushDone on that cycle still wins.
    assign w_timeout_hit = (r_state == ST_FLUSH) && !bus.flushDone && (r_flush_cnt == c_cnt_last);
    assign w_flush_req   = !r_illegal && (bus.snoopState == MESI_M)
                           && ((r_cmd == CMD_BUSRD) || (r_cmd == CMD_BUSRDX));
    assign bus.shared    = r_shared;

    always_comb begin
        w_next     = r_state;
        bus.grant  = 2'b00;
        bus.busCmd = CMD_EMPTY;
        bus.done   = 2'b00;
        bus.err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req != 2'b00) w_next = ST_GRANT;
            end
            ST_GRANT: begin
                bus.grant  = w_grant_vec;
                bus.busCmd = w_cmd_out;
                w_next     = ST_SNOOP;
            end
            ST_SNOOP: begin
                bus.grant  = w_grant_vec;
                bus.busCmd = w_cmd_out;
                w_next     = w_flush_req ? ST_FLUSH : ST_DONE;
            end
            ST_FLUSH: begin
                bus.grant  = w_grant_vec;
                bus.busCmd = w_cmd_out;
                if (bus.flushDone || w_timeout_hit) w_next = ST_DONE;
            end
            ST_DONE: begin
                bus.grant = w_grant_vec;
                bus.done  = w_grant_vec;
                bus.err   = r_illegal || r_timeout;
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_cmd       <= CMD_EMPTY;
            r_illegal   <= 1'b0;
            r_timeout   <= 1'b0;
            r_shared    <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req != 2'b00) begin
                        r_owner   <= w_win1;
                        r_cmd     <= w_win1 ? bus.reqCmd1 : bus.reqCmd0;
                        r_illegal <= !is_legal_cmd(w_win1 ? bus.reqCmd1 : bus.reqCmd0);
                        r_timeout <= 1'b0;
                    end
                end
                ST_SNOOP: begin
                    r_shared <= (r_cmd == CMD_BUSRD)
                                && (bus.snoopState inside {MESI_S, MESI_E, MESI_M});
                    if (w_next == ST_FLUSH) r_flush_cnt <= '0;
                end
                ST_FLUSH: begin
                    if (r_flush_cnt != c_cnt_last) r_flush_cnt <= r_flush_cnt + c_cnt_w'(1);
                    r_timeout <= w_timeout_hit;
                end
                ST_DONE: begin
                    r_last <= r_owner;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`default_nettype none
//============================================================================
// Module : tb_snoop_bus_arbiter
// Directed vector table plus flush, timeout, reset and round-robin sequences.
// Rev    : 1.0
//============================================================================
module tb_snoop_bus_arbiter;
    import snoop_pkg::*;

    localparam int FLUSH_TIMEOUT = 8;

    typedef struct packed {
        logic [1:0] req;
        logic [2:0] cmd0;
        logic [2:0] cmd1;
        logic [2:0] snoop;
        logic [1:0] grant;
        logic [2:0] bus;
        logic       shared;
        logic       err;
    } vec_t;

    logic Clock;
    logic Resetn;
    int   n_checks = 0;
    int   n_pass   = 0;

    snoop_bus_arbiter_if bus ();

    snoop_bus_arbiter #(.FLUSH_TIMEOUT(FLUSH_TIMEOUT)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One non-flush transaction: inputs in IDLE, then GRANT, SNOOP, DONE, IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        bus.req        = v.req;
        bus.reqCmd0    = v.cmd0;
        bus.reqCmd1    = v.cmd1;
        bus.snoopState = v.snoop;
        tick();
        chk({tag, " grant@GRANT"}, 8'(bus.grant), 8'(v.grant));
        chk({tag, " busCmd@GRANT"}, 8'(bus.busCmd), 8'(v.bus));
        bus.req       = 2'b00;
        bus.reqCmd0   = 3'b111;
        bus.reqCmd1   = 3'b111;
        bus.flushDone = 1'b1;
        tick();
        bus.flushDone = 1'b0;
        chk({tag, " grant@SNOOP"}, 8'(bus.grant), 8'(v.grant));
        chk({tag, " busCmd@SNOOP"}, 8'(bus.busCmd), 8'(v.bus));
        tick();
        chk({tag, " done@DONE"}, 8'(bus.done), 8'(v.grant));
        chk({tag, " err@DONE"}, 8'(bus.err), 8'(v.err));
        chk({tag, " busCmd@DONE"}, 8'(bus.busCmd), 8'h0);
        chk({tag, " shared@DONE"}, 8'(bus.shared), 8'(v.shared));
        bus.snoopState = MESI_M;
        tick();
        chk({tag, " grant@IDLE"}, 8'(bus.grant), 8'h0);
        chk({tag, " done@IDLE"}, 8'(bus.done), 8'h0);
        chk({tag, " shared hold"}, 8'(bus.shared), 8'(v.shared));
    endtask

    vec_t vecs[10];
    logic [1:0] rr_exp[3];

    initial begin
        //            req    cmd0    cmd1    snoop   grant  bus     sh    err
        vecs[0] = '{2'b01, 3'b001, 3'b000, 3'b001, 2'b01, 3'b001, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 3'b001, 3'b000, 3'b100, 2'b01, 3'b001, 1'b1, 1'b0};
        vecs[2] = '{2'b01, 3'b011, 3'b000, 3'b010, 2'b01, 3'b011, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 3'b001, 3'b001, 3'b010, 2'b10, 3'b001, 1'b1, 1'b0};
        vecs[4] = '{2'b11, 3'b001, 3'b001, 3'b001, 2'b01, 3'b001, 1'b0, 1'b0};
        vecs[5] = '{2'b11, 3'b001, 3'b010, 3'b010, 2'b10, 3'b010, 1'b0, 1'b0};
        vecs[6] = '{2'b10, 3'b000, 3'b011, 3'b011, 2'b10, 3'b011, 1'b0, 1'b0};
        vecs[7] = '{2'b01, 3'b000, 3'b000, 3'b010, 2'b01, 3'b000, 1'b0, 1'b1};
        vecs[8] = '{2'b10, 3'b000, 3'b101, 3'b011, 2'b10, 3'b000, 1'b0, 1'b1};
        vecs[9] = '{2'b01, 3'b010, 3'b000, 3'b001, 2'b01, 3'b010, 1'b0, 1'b0};
        rr_exp[0] = 2'b01;
        rr_exp[1] = 2'b10;
        rr_exp[2] = 2'b01;

        Resetn         = 1'b0;
        bus.req        = 2'b00;
        bus.reqCmd0    = 3'b000;
        bus.reqCmd1    = 3'b000;
        bus.snoopState = MESI_I;
        bus.flushDone  = 1'b0;
        #1;
        chk("reset grant", 8'(bus.grant), 8'h0);
        chk("reset busCmd", 8'(bus.busCmd), 8'h0);
        chk("reset shared", 8'(bus.shared), 8'h0);
        chk("reset done", 8'(bus.done), 8'h0);
        chk("reset err", 8'(bus.err), 8'h0);
        tick();
        tick();
        Resetn = 1'b1;
        tick();
        chk("idle grant", 8'(bus.grant), 8'h0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Flush completed by flushDone in the third FLUSH cycle.
        bus.req = 2'b10; bus.reqCmd1 = CMD_BUSRDX; bus.snoopState = MESI_M;
        tick();
        chk("flush grant@GRANT", 8'(bus.grant), 8'h2);
        bus.req = 2'b00;
        tick();
        tick();
        chk("flush busCmd@F1", 8'(bus.busCmd), 8'h2);
        chk("flush done@F1", 8'(bus.done), 8'h0);
        tick();
        chk("flush done@F2", 8'(bus.done), 8'h0);
        tick();
        chk("flush busCmd@F3", 8'(bus.busCmd), 8'h2);
        chk("flush done@F3", 8'(bus.done), 8'h0);
        bus.flushDone = 1'b1;
        tick();
        bus.flushDone = 1'b0;
        chk("flush done@DONE", 8'(bus.done), 8'h2);
        chk("flush err@DONE", 8'(bus.err), 8'h0);
        chk("flush busCmd@DONE", 8'(bus.busCmd), 8'h0);
        tick();

        // Flush never acknowledged: forced completion after FLUSH_TIMEOUT cycles.
        bus.req = 2'b10; bus.reqCmd1 = CMD_BUSRDX; bus.snoopState = MESI_M;
        tick();
        bus.req = 2'b00;
        tick();
        for (int k = 1; k <= FLUSH_TIMEOUT; k++) begin
            tick();
            chk($sformatf("timeout done@F%0d", k), 8'(bus.done), 8'h0);
            chk($sformatf("timeout grant@F%0d", k), 8'(bus.grant), 8'h2);
        end
        tick();
        chk("timeout done@DONE", 8'(bus.done), 8'h2);
        chk("timeout err@DONE", 8'(bus.err), 8'h1);
        tick();
        chk("timeout err@IDLE", 8'(bus.err), 8'h0);

        // Leave the pointer at cache 0 so a tie would go to cache 1 without reset.
        run_vec('{2'b01, 3'b001, 3'b000, 3'b001, 2'b01, 3'b001, 1'b0, 1'b0}, "pre");

        // Reset asserted mid-SNOOP, then regrant on the first posedge after release.
        bus.req = 2'b11; bus.reqCmd0 = CMD_BUSRD; bus.reqCmd1 = CMD_BUSRD;
        bus.snoopState = MESI_S;
        tick();
        chk("rst grant@GRANT", 8'(bus.grant), 8'h2);
        tick();
        #2;
        Resetn = 1'b0;
        #1;
        chk("rst grant async", 8'(bus.grant), 8'h0);
        chk("rst busCmd async", 8'(bus.busCmd), 8'h0);
        chk("rst shared async", 8'(bus.shared), 8'h0);
        tick();
        chk("rst no done", 8'(bus.done), 8'h0);
        Resetn = 1'b1;
        bus.snoopState = MESI_I;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk($sformatf("rr%0d grant@GRANT", t), 8'(bus.grant), 8'(rr_exp[t]));
            tick();
            tick();
            chk($sformatf("rr%0d done@DONE", t), 8'(bus.done), 8'(rr_exp[t]));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
